// File: rtl/obi_bank_arbiter_if.sv
// Bus bundle between NMASTER OBI masters, the bank arbiter and one RAM bank.
//
// master_* : per-master request fields (req, we, be, addr, wdata) going in,
//            per-master gnt/rvalid and a shared rdata coming back.
// slave_*  : the single request toward the bank and the bank's response.
//
// Handshake rule on every OBI link in this bundle: a request beat transfers
// in the cycle where req and gnt are both high. A master that raised req
// keeps req and its fields stable until that cycle. A response beat is
// delivered in every cycle where rvalid is high. There is no backpressure on
// responses.
//
// Modports:
//   slave  : the arbiter's view (it serves the masters, drives the bank).
//   master : the environment's view (masters plus bank), the mirror image.
interface obi_bank_arbiter_if #(
    parameter int NMASTER = 4,
    parameter int AW      = 32,
    parameter int DW      = 32
);
    logic [NMASTER-1:0]              master_req;
    logic [NMASTER-1:0]              master_we;
    logic [NMASTER-1:0][DW/8-1:0]    master_be;
    logic [NMASTER-1:0][AW-1:0]      master_addr;
    logic [NMASTER-1:0][DW-1:0]      master_wdata;
    logic [NMASTER-1:0]              master_gnt;
    logic [NMASTER-1:0]              master_rvalid;
    logic [DW-1:0]                   master_rdata;

    logic                            slave_req;
    logic                            slave_we;
    logic [DW/8-1:0]                 slave_be;
    logic [AW-1:0]                   slave_addr;
    logic [DW-1:0]                   slave_wdata;
    logic                            slave_gnt;
    logic                            slave_rvalid;
    logic [DW-1:0]                   slave_rdata;

    modport slave (
        input  master_req, master_we, master_be, master_addr, master_wdata,
        output master_gnt, master_rvalid, master_rdata,
        output slave_req, slave_we, slave_be, slave_addr, slave_wdata,
        input  slave_gnt, slave_rvalid, slave_rdata
    );

    modport master (
        output master_req, master_we, master_be, master_addr, master_wdata,
        input  master_gnt, master_rvalid, master_rdata,
        input  slave_req, slave_we, slave_be, slave_addr, slave_wdata,
        output slave_gnt, slave_rvalid, slave_rdata
    );
endinterface

// File: rtl/obi_bank_arbiter.sv
// Shares one OBI bank port between NMASTER OBI masters.
//
// Round-robin arbitration with request locking: once a request is presented
// to the bank without gnt, the selection is held on that master until the
// handshake, so the bank sees stable address/data. Each handshake pushes the
// winning master index into an in-order ID FIFO, and each bank rvalid pops
// that FIFO to route the response back to the master that issued it.
//
// Ports:
//   clk_i, rst_i    clock, asynchronous active-high reset
//   bus             obi_bank_arbiter_if.slave (master side + bank side)
//   outstanding_o   number of issued transactions still awaiting rvalid
//   err_rvalid_o    sticky: bank rvalid arrived with nothing outstanding
//   err_clr_i       clears err_rvalid_o (a same-cycle new error wins)
//   arb_state_o     arbiter state, 1 = LOCKED, 0 = IDLE
module obi_bank_arbiter #(
    parameter int NMASTER         = 4,
    parameter int MAX_OUTSTANDING = 2,
    localparam int IDX_W          = $clog2(NMASTER),
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obi_bank_arbiter_if.slave  bus,
    output logic [CNT_W-1:0]   outstanding_o,
    output logic               err_rvalid_o,
    input  logic               err_clr_i,
    output logic               arb_state_o
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [IDX_W-1:0] RR_RESET  = IDX_W'(NMASTER - 1);

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_idx;
    logic [IDX_W-1:0]   rr_sel;
    logic [IDX_W-1:0]   rr_cand;
    logic               rr_found;
    logic [IDX_W-1:0]   sel;

    logic [IDX_W-1:0]   id_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_full;
    logic               fifo_empty;
    logic [IDX_W-1:0]   head;

    logic               handshake;
    logic               push;
    logic               pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Round-robin search upward from rr_ptr+1; the last winner gets lowest
    // priority, so a lone requester still wins every cycle.
    always_comb begin
        rr_sel   = rr_ptr;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= NMASTER; k++) begin
            rr_cand = IDX_W'((int'(rr_ptr) + k) % NMASTER);
            if (!rr_found && bus.master_req[rr_cand]) begin
                rr_sel   = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    assign sel = (state == ARB_LOCKED) ? lock_idx : rr_sel;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    assign head       = id_fifo[rd_ptr];

    // Full blocks forwarding even when the same cycle pops: there is
    // deliberately no combinational rvalid-to-req path. Reset also gates the
    // request so the bank sees req=0 as soon as rst_i rises.
    assign bus.slave_req   = bus.master_req[sel] & ~fifo_full & ~rst_i;
    assign bus.slave_we    = bus.master_we[sel];
    assign bus.slave_be    = bus.master_be[sel];
    assign bus.slave_addr  = bus.master_addr[sel];
    assign bus.slave_wdata = bus.master_wdata[sel];

    assign handshake = bus.slave_req & bus.slave_gnt;
    assign push      = handshake;
    assign pop       = bus.slave_rvalid & ~fifo_empty;

    // rdata is broadcast; only the owner of the FIFO head sees rvalid.
    assign bus.master_rdata = bus.slave_rdata;

    always_comb begin
        bus.master_gnt    = '0;
        bus.master_rvalid = '0;
        for (int i = 0; i < NMASTER; i++) begin
            bus.master_gnt[i]    = handshake & (sel == IDX_W'(i));
            bus.master_rvalid[i] = pop & (head == IDX_W'(i));
        end
    end

    // Arbiter FSM: rr pointer, lock state and latched index.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ARB_IDLE;
            rr_ptr   <= RR_RESET;
            lock_idx <= '0;
        end else begin
            if (handshake) begin
                rr_ptr <= sel;
            end
            case (state)
                ARB_IDLE: begin
                    if (bus.slave_req && !bus.slave_gnt) begin
                        state    <= ARB_LOCKED;
                        lock_idx <= sel;
                    end
                end
                ARB_LOCKED: begin
                    if (handshake) begin
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Response-routing ID FIFO.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                id_fifo[i] <= '0;
            end
        end else begin
            if (push) begin
                id_fifo[wr_ptr] <= sel;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky error for a response with nothing outstanding; set beats clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_rvalid_o <= 1'b0;
        end else if (bus.slave_rvalid && fifo_empty) begin
            err_rvalid_o <= 1'b1;
        end else if (err_clr_i) begin
            err_rvalid_o <= 1'b0;
        end
    end

    assign outstanding_o = count;
    assign arb_state_o   = (state == ARB_LOCKED);

endmodule
